// File: rtl/game_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_frame_sequencer
// Brief    : Button debounce, per-frame game tick and IDLE/PLAY/DYING/OVER FSM
//            between the processor, the flap button and the VGA controller.
// Revision : 1.0 - initial release
// ============================================================================
module game_frame_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEATH_FRAMES    = 60,
  parameter int RESTART_CYCLES  = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         button_pressed,
  input  logic         vga_vs,
  input  logic         collision_flag,
  input  logic [31:0]  game_score,
  input  logic [223:0] obj_in,
  output logic [223:0] obj_out,
  output logic         game_tick,
  output logic         flap,
  output logic         proc_reset,
  output logic         gameover_flag,
  output logic [31:0]  score_disp,
  output logic [31:0]  high_score,
  output logic [1:0]   state
);

  localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_rs_w = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam int c_df_w = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rs_w-1:0] c_rs_max = c_rs_w'(RESTART_CYCLES - 1);
  localparam logic [c_df_w-1:0] c_df_max = c_df_w'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DYING   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_btn_s1;
  logic               r_btn_s2;
  logic               r_vs_s1;
  logic               r_vs_s2;
  logic               r_vs_s3;
  logic               r_frame_evt;
  logic               w_btn;
  logic [c_db_w-1:0]  r_db_cnt;
  logic               r_btn_level;
  logic               r_btn_level_d;
  logic               r_press_evt;
  logic [c_rs_w-1:0]  r_rs_cnt;
  logic [c_df_w-1:0]  r_df_cnt;
  logic               r_flap_pending;

  // Synchronisers; vsync idles high so its chain resets to 1 to avoid a fake frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_vs_s1     <= 1'b1;
      r_vs_s2     <= 1'b1;
      r_vs_s3     <= 1'b1;
      r_frame_evt <= 1'b0;
    end else begin
      r_btn_s1    <= button_pressed;
      r_btn_s2    <= r_btn_s1;
      r_vs_s1     <= vga_vs;
      r_vs_s2     <= r_vs_s1;
      r_vs_s3     <= r_vs_s2;
      r_frame_evt <= r_vs_s3 & ~r_vs_s2;
    end
  end

  assign w_btn = ~r_btn_s2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_db_cnt      <= '0;
      r_btn_level   <= 1'b0;
      r_btn_level_d <= 1'b0;
      r_press_evt   <= 1'b0;
    end else begin
      r_btn_level_d <= r_btn_level;
      r_press_evt   <= r_btn_level & ~r_btn_level_d;
      if (w_btn == r_btn_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_max) begin
        r_btn_level <= w_btn;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    proc_reset    = 1'b0;
    gameover_flag = 1'b0;
    state         = 2'd0;
    case (r_state)
      ST_IDLE: begin
        proc_reset = 1'b1;
        if (r_press_evt) w_state_nxt = ST_RESTART;
      end
      ST_RESTART: begin
        proc_reset = 1'b1;
        state      = 2'd1;
        if (r_rs_cnt == c_rs_max) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        state = 2'd2;
        if (r_frame_evt && collision_flag) w_state_nxt = ST_DYING;
      end
      ST_DYING: begin
        gameover_flag = 1'b1;
        state         = 2'd3;
        if (r_frame_evt && (r_df_cnt == c_df_max)) w_state_nxt = ST_OVER;
      end
      ST_OVER: begin
        gameover_flag = 1'b1;
        state         = 2'd3;
        if (r_press_evt) w_state_nxt = ST_RESTART;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rs_cnt <= '0;
      r_df_cnt <= '0;
    end else begin
      if (r_state == ST_RESTART) r_rs_cnt <= r_rs_cnt + 1'b1;
      else                       r_rs_cnt <= '0;
      if (r_state != ST_DYING)   r_df_cnt <= '0;
      else if (r_frame_evt)      r_df_cnt <= r_df_cnt + 1'b1;
    end
  end

  // Presses between ticks collapse into one pending flap for the next frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      obj_out        <= '0;
      game_tick      <= 1'b0;
      flap           <= 1'b0;
      score_disp     <= '0;
      high_score     <= '0;
      r_flap_pending <= 1'b0;
    end else begin
      game_tick <= 1'b0;
      flap      <= 1'b0;
      if (r_frame_evt) obj_out <= obj_in;
      if (r_state == ST_PLAY) begin
        if (r_frame_evt) begin
          game_tick      <= 1'b1;
          flap           <= r_flap_pending | r_press_evt;
          r_flap_pending <= 1'b0;
          score_disp     <= game_score;
          if (collision_flag && (game_score > high_score)) high_score <= game_score;
        end else if (r_press_evt) begin
          r_flap_pending <= 1'b1;
        end
      end else if (r_state == ST_RESTART) begin
        r_flap_pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
